// File: rtl/alu_io_pkg.sv
// Shared types and key-code layout for the calculator I/O path (keypad in, display out).
// The keypad code is {row[1:0], col[1:0]}, so a key's code equals row*4 + col.
package alu_io_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_t;

    localparam int KP_ROWS     = 4;
    localparam int KP_COLS     = 4;
    localparam int KEY_W       = 4;
    localparam int KEY_COL_LSB = 0;
    localparam int KEY_COL_W   = 2;
    localparam int KEY_ROW_LSB = 2;
    localparam int KEY_ROW_W   = 2;

    // Index of the lowest-numbered active-low column; 0 when none is low.
    function automatic logic [KEY_COL_W-1:0] lowest_low_col(input logic [KP_COLS-1:0] col);
        logic [KEY_COL_W-1:0] idx;
        idx = '0;
        for (int i = KP_COLS - 1; i >= 0; i--) begin
            if (!col[i]) idx = KEY_COL_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [KEY_W-1:0] pack_key(input logic [KEY_ROW_W-1:0] row,
                                                  input logic [KEY_COL_W-1:0] col);
        logic [KEY_W-1:0] code;
        code = '0;
        code[KEY_ROW_LSB +: KEY_ROW_W] = row;
        code[KEY_COL_LSB +: KEY_COL_W] = col;
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// Row-dwell timebase: a one-mclk tick every SCAN_DIV cycles.
// The counter runs 0..SCAN_DIV-1 and the tick coincides with the terminal count.
module scan_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic mclk,
    input  logic rst_n,
    output logic tick
);

    localparam int              CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates one low row, debounces press and release of the
// latched key, and hands one code per press to the consumer over valid/ready.
module keypad_scanner
    import alu_io_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic                mclk,
    input  logic                rst_n,
    input  logic [KP_COLS-1:0]  col_n,
    output logic [KP_ROWS-1:0]  row_n,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_overrun,
    input  logic                ovr_clr
);

    localparam int              DB_W    = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

    logic                 tick;
    logic [KP_COLS-1:0]   col_p0;
    logic [KP_COLS-1:0]   col_s;

    kp_state_t            state, state_nxt;
    logic [KEY_ROW_W-1:0] row_idx, row_idx_nxt;
    logic [KEY_COL_W-1:0] lat_col, lat_col_nxt;
    logic [DB_W-1:0]      db_cnt, db_cnt_nxt;
    logic                 emit;
    logic                 accept;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .mclk  (mclk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Column synchronizer (col_n is asynchronous to mclk)
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            col_p0 <= '1;
            col_s  <= '1;
        end else begin
            col_p0 <= col_n;
            col_s  <= col_p0;
        end
    end

    // Next-state logic: everything advances only on a scan tick. The row stays frozen
    // while a key is latched, so row_idx doubles as the latched row.
    always_comb begin
        state_nxt   = state;
        row_idx_nxt = row_idx;
        lat_col_nxt = lat_col;
        db_cnt_nxt  = db_cnt;
        emit        = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (col_s != '1) begin
                        lat_col_nxt = lowest_low_col(col_s);
                        db_cnt_nxt  = '0;
                        state_nxt   = DEBOUNCE;
                    end else begin
                        row_idx_nxt = row_idx + KEY_ROW_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!col_s[lat_col]) begin
                        if (db_cnt == DB_LAST) begin
                            db_cnt_nxt = '0;
                            state_nxt  = HELD;
                            emit       = 1'b1;
                        end else begin
                            db_cnt_nxt = db_cnt + DB_W'(1);
                        end
                    end else begin
                        db_cnt_nxt  = '0;
                        state_nxt   = SCAN;
                        row_idx_nxt = row_idx + KEY_ROW_W'(1);
                    end
                end
                HELD: begin
                    if (col_s[lat_col]) begin
                        if (db_cnt == DB_LAST) begin
                            db_cnt_nxt  = '0;
                            state_nxt   = SCAN;
                            row_idx_nxt = row_idx + KEY_ROW_W'(1);
                        end else begin
                            db_cnt_nxt = db_cnt + DB_W'(1);
                        end
                    end else begin
                        db_cnt_nxt = '0;
                    end
                end
                default: begin
                    db_cnt_nxt = '0;
                    state_nxt  = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SCAN;
            row_idx <= '0;
            row_n   <= 4'b1110;
            lat_col <= '0;
            db_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            row_idx <= row_idx_nxt;
            row_n   <= ~(KP_ROWS'(1) << row_idx_nxt);
            lat_col <= lat_col_nxt;
            db_cnt  <= db_cnt_nxt;
        end
    end

    // A new key may land when the slot is empty or is being drained this same cycle.
    assign accept = !key_valid || key_ready;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_overrun <= 1'b0;
        end else begin
            if (emit && accept) begin
                key_code  <= pack_key(row_idx, lat_col);
                key_valid <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
            if (emit && !accept) begin
                key_overrun <= 1'b1;
            end else if (ovr_clr) begin
                key_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives the columns from a 16-bit key mask,
// expected codes go into a queue and a negedge monitor pops them on each transfer.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DB_TICKS = 3;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic        key_overrun;
    logic        ovr_clr = 1'b0;

    logic [15:0] keys = '0;     // bit (row*4 + col) set = key held down
    logic [3:0]  exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          valid_cycles = 0;
    logic        rnd_ready = 1'b0;

    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [3:0]  prev_code = '0;

    always #5 mclk = ~mclk;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DB_TICKS)
    ) dut (
        .mclk        (mclk),
        .rst_n       (rst_n),
        .col_n       (col_n),
        .row_n       (row_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_overrun (key_overrun),
        .ovr_clr     (ovr_clr)
    );

    // Keypad: the active (low) row shorts its pressed keys onto the columns.
    always_comb begin
        logic [3:0] sel;
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            sel = ~(4'(1 << r));
            if (row_n == sel) col_n = ~keys[r*4 +: 4];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: held data must stay put, and each transfer must match the queue head.
    always @(negedge mclk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (key_valid) valid_cycles <= valid_cycles + 1;
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", int'(key_valid), 1);
                chk("hold_code", int'(key_code), int'(prev_code));
            end
            if (key_valid && key_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key: got %0h expected none at %0t", key_code, $time);
                end else begin
                    chk("key_code", int'(key_code), int'(exp_q.pop_front()));
                end
            end
            prev_valid <= key_valid;
            prev_ready <= key_ready;
            prev_code  <= key_code;
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge mclk);
            #1;
            if (rnd_ready) key_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc(1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge mclk);
            @(negedge mclk);
            n = i;
            if (key_valid) break;
        end
        if (!key_valid) n = -1;
    endtask

    task automatic reset_pulse();
        @(posedge mclk);
        #1 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic press(input int k, input int hold, input int gap);
        keys[k] = 1'b1;
        cyc(hold);
        keys[k] = 1'b0;
        cyc(gap);
    endtask

    initial begin
        int n;
        int v0;
        logic [3:0] erow;

        // Reset values
        #12;
        chk("rst_row_n", int'(row_n), 4'hE);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_code", int'(key_code), 0);
        chk("rst_overrun", int'(key_overrun), 0);

        // 1: idle scan, one row per SCAN_DIV cycles after release
        @(posedge mclk);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge mclk);
            @(negedge mclk);
            erow = ~(4'(1 << ((i / SCAN_DIV) % 4)));
            chk("idle_row_n", int'(row_n), int'(erow));
        end
        chk("idle_no_key", valid_cycles, 0);

        // 2: r2c1 held from reset; row 2 is sampled on the tick ending cycle 11,
        // confirmed on the tick ending cycle 23, code visible after edge 24
        key_ready = 1'b1;
        keys[9] = 1'b1;
        exp_q.push_back(4'b1001);
        @(posedge mclk);
        #1 rst_n = 1'b0;
        cyc(2);
        v0 = valid_cycles;
        rst_n = 1'b1;
        wait_valid(60, n);
        chk("latency_r2c1", n, 24);
        cyc(200);
        chk("single_pulse", valid_cycles - v0, 1);
        keys = '0;
        cyc(40);
        wait_empty(10);

        // 3: r1c3 bounces, then settles
        exp_q.push_back(4'b0111);
        v0 = valid_cycles;
        for (int b = 0; b < 2; b++) begin
            keys[7] = 1'b1;
            cyc(SCAN_DIV);
            keys[7] = 1'b0;
            cyc(SCAN_DIV);
        end
        keys[7] = 1'b1;
        cyc(8);
        chk("bounce_quiet", valid_cycles - v0, 0);
        cyc(100);
        keys[7] = 1'b0;
        cyc(60);
        wait_empty(10);

        // 4: consumer stalled: second key is dropped and flagged
        key_ready = 1'b0;
        exp_q.push_back(4'b0000);
        press(0, 100, 60);
        press(14, 100, 60);
        chk("ovr_valid", int'(key_valid), 1);
        chk("ovr_code", int'(key_code), 0);
        chk("ovr_set", int'(key_overrun), 1);
        ovr_clr = 1'b1;
        cyc(1);
        ovr_clr = 1'b0;
        @(negedge mclk);
        chk("ovr_cleared", int'(key_overrun), 0);
        cyc(1);
        key_ready = 1'b1;
        wait_empty(10);
        cyc(80);

        // 5: two columns on one row, lowest column wins
        exp_q.push_back(4'b0100);
        keys[4] = 1'b1;
        keys[6] = 1'b1;
        cyc(100);
        keys = '0;
        cyc(60);
        wait_empty(10);

        // 6a: reset with a pending key and a set overrun flag
        key_ready = 1'b0;
        keys[15] = 1'b1;
        wait_valid(100, n);
        chk("pend_code", int'(key_code), 4'hF);
        keys = '0;
        cyc(60);
        press(2, 100, 60);
        chk("pend_overrun", int'(key_overrun), 1);
        @(posedge mclk);
        #1 rst_n = 1'b0;
        #1;
        chk("rstp_valid", int'(key_valid), 0);
        chk("rstp_code", int'(key_code), 0);
        chk("rstp_overrun", int'(key_overrun), 0);
        chk("rstp_row_n", int'(row_n), 4'hE);
        keys[1] = 1'b1;
        cyc(2);
        rst_n = 1'b1;

        // 6b: r0c1 held through reset is in debounce by edge 8; reset it there
        cyc(8);
        rst_n = 1'b0;
        #1;
        chk("rstd_row_n", int'(row_n), 4'hE);
        chk("rstd_valid", int'(key_valid), 0);
        keys = '0;
        cyc(3);
        rst_n = 1'b1;
        cyc(40);
        chk("rstd_no_key", int'(key_valid), 0);
        key_ready = 1'b1;
        exp_q.push_back(4'b1011);
        press(11, 100, 60);
        wait_empty(10);

        // Randomized presses with random bounce and random consumer back-pressure
        rnd_ready = 1'b1;
        for (int it = 0; it < 15; it++) begin
            int k;
            k = $urandom_range(0, 15);
            exp_q.push_back(4'(k));
            if ($urandom_range(0, 1) == 1) begin
                keys[k] = 1'b1;
                cyc(SCAN_DIV);
                keys[k] = 1'b0;
                cyc(SCAN_DIV);
            end
            press(k, $urandom_range(70, 120), $urandom_range(45, 80));
        end
        rnd_ready = 1'b0;
        key_ready = 1'b1;
        wait_empty(100);
        chk("rand_no_overrun", int'(key_overrun), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
